// File: rtl/audio_i2s_tx.sv
// I2S transmitter for the SAA1099 stereo output: divides clk_sys into BCLK/LRCK and shifts 16-bit words MSB first.
// Define AUDIO_I2S_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit delay after each LRCK edge).
module audio_i2s_tx #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] in_l,
  input  logic [7:0] in_r,
  output logic       sample_req,
  output logic       i2s_bclk,
  output logic       i2s_lrck,
  output logic       i2s_data
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

`ifdef AUDIO_I2S_LEFT_JUSTIFIED_EN
  // Slot starts at 31 so the first falling edge after reset enters slot 0 and loads there.
  localparam logic [4:0] SLOT_RST  = 5'd31;
  localparam logic [4:0] LOAD_SLOT = 5'd0;
`else
  localparam logic [4:0] SLOT_RST  = 5'd0;
  localparam logic [4:0] LOAD_SLOT = 5'd1;
`endif

  function automatic logic [15:0] to_word(input logic enable, input logic [7:0] smp);
    logic [15:0] w;
    if (enable) begin
      w = {smp ^ 8'h80, 8'h00};
    end else begin
      w = 16'h0000;
    end
    return w;
  endfunction

  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        bclk_q, bclk_d;
  logic [4:0]  slot_q, slot_d;
  logic        lrck_q, lrck_d;
  logic        data_q, data_d;
  logic [31:0] shreg_q, shreg_d;
  logic        req_q, req_d;

  logic        div_term_s;
  logic        fe_s;
  logic [4:0]  slot_nxt_s;
  logic [15:0] word_l_s;

  // Next-state logic: divider every cycle, framing only on BCLK falling-edge cycles.
  always_comb begin
    div_term_s = (div_cnt_q == DIV_LAST);
    fe_s       = div_term_s & bclk_q;
    slot_nxt_s = slot_q + 5'd1;
    word_l_s   = to_word(en, in_l);

    if (div_term_s) begin
      div_cnt_d = 8'd0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 8'd1;
      bclk_d    = bclk_q;
    end

    slot_d  = slot_q;
    lrck_d  = lrck_q;
    data_d  = data_q;
    shreg_d = shreg_q;
    req_d   = 1'b0;

    if (fe_s) begin
      slot_d = slot_nxt_s;
      lrck_d = slot_nxt_s[4];
      if (slot_nxt_s == LOAD_SLOT) begin
        shreg_d = {word_l_s, to_word(en, in_r)};
        data_d  = word_l_s[15];
        req_d   = 1'b1;
      end else begin
        shreg_d = {shreg_q[30:0], 1'b0};
        data_d  = shreg_q[30];
      end
    end else begin
      req_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= 8'd0;
      bclk_q    <= 1'b0;
      slot_q    <= SLOT_RST;
      lrck_q    <= 1'b0;
      data_q    <= 1'b0;
      shreg_q   <= 32'h0000_0000;
      req_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      slot_q    <= slot_d;
      lrck_q    <= lrck_d;
      data_q    <= data_d;
      shreg_q   <= shreg_d;
      req_q     <= req_d;
    end
  end

  assign sample_req = req_q;
  assign i2s_bclk   = bclk_q;
  assign i2s_lrck   = lrck_q;
  assign i2s_data   = data_q;

endmodule
